// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage loads/stores from a 16-bit async
// SRAM as two half-word phases, holding ready low while an access is in flight.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   wr_en, rd_en             MEM-stage requests (write wins when both set)
//   address, write_data      byte address and store data
//   read_data                load data, held until the next read completes
//   ready                    0 = pipeline must freeze
//   sram_addr                half-word address (low half even, high half odd)
//   sram_dq_out, sram_dq_in  SRAM data out / in
//   sram_dq_oe               1 = controller drives the DQ bus
//   sram_we_n                SRAM write strobe, active-low
module sram_controller #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          WAIT_CYCLES = 5,
    parameter int          SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   op_wr_q, op_wr_d;
    logic [SRAM_ADDR_W-2:0] w_q, w_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]            dq_q, dq_d;
    logic                   oe_q, oe_d;
    logic                   we_n_q, we_n_d;

    logic                   req;
    logic [SRAM_ADDR_W-2:0] w_in;

    assign req = wr_en | rd_en;

    // Word index with modular wrap: addresses outside the SRAM fold back.
    assign w_in = (SRAM_ADDR_W-1)'((address - ADDR_BASE) >> 2);

    // Pin values are registered so they change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        w_d     = w_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        oe_d    = oe_q;
        we_n_d  = we_n_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = CNT_LOAD;
                    op_wr_d = wr_en;
                    w_d     = w_in;
                    wdata_d = write_data;
                    addr_d  = {w_in, 1'b0};
                    oe_d    = wr_en;
                    we_n_d  = ~wr_en;
                    if (wr_en) begin
                        dq_d = write_data[15:0];
                    end
                end
            end
            LO: begin
                if (cnt_q == '0) begin
                    state_d = HI;
                    cnt_d   = CNT_LOAD;
                    addr_d  = {w_q, 1'b1};
                    if (op_wr_q) begin
                        dq_d = wdata_q[31:16];
                    end else begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HI: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            w_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            w_q     <= w_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
        end
    end

    // A request seen in IDLE freezes the pipeline in that same cycle.
    assign ready = ~((state_q == IDLE && req) ||
                     state_q == LO || state_q == HI);

    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench for sram_controller with WAIT_CYCLES=5
// (instance 0) and WAIT_CYCLES=1 (instance 1), checked by a per-cycle model.
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en      [2];
    logic        rd_en      [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] dq_out     [2];
    logic [15:0] dq_in      [2];
    logic        dq_oe      [2];
    logic        we_n       [2];

    bit [15:0] smem [2][262144];

    int tests = 0;
    int fails = 0;

    sram_controller #(
        .ADDR_BASE(32'd1024), .WAIT_CYCLES(5), .SRAM_ADDR_W(18)
    ) u_w5 (
        .clk(clk), .rst(rst_n),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]),
        .address(address[0]), .write_data(write_data[0]),
        .read_data(read_data[0]), .ready(ready[0]),
        .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]),
        .sram_dq_in(dq_in[0]), .sram_dq_oe(dq_oe[0]),
        .sram_we_n(we_n[0])
    );

    sram_controller #(
        .ADDR_BASE(32'd1024), .WAIT_CYCLES(1), .SRAM_ADDR_W(18)
    ) u_w1 (
        .clk(clk), .rst(rst_n),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]),
        .address(address[1]), .write_data(write_data[1]),
        .read_data(read_data[1]), .ready(ready[1]),
        .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]),
        .sram_dq_in(dq_in[1]), .sram_dq_oe(dq_oe[1]),
        .sram_we_n(we_n[1])
    );

    // Asynchronous SRAM stand-in: combinational read, write while we_n is low.
    assign dq_in[0] = smem[0][sram_addr[0]];
    assign dq_in[1] = smem[1][sram_addr[1]];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (we_n[d] === 1'b0) smem[d][sram_addr[d]] <= dq_out[d];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: cycle k of a transaction started at k=0.
    bit          busy   [2];
    int          k      [2];
    bit          opw    [2];
    int          lo_a   [2];
    logic [31:0] wd     [2];
    logic [31:0] exp_rd [2];
    bit [15:0]   emem   [int];
    int          wc, key, exp_a;
    logic [31:0] wi;
    bit          inph, hiph;

    function automatic bit [15:0] mrd(input int a);
        return emem.exists(a) ? emem[a] : 16'h0;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            wc = (d == 0) ? 5 : 1;
            if (!rst_n) begin
                busy[d]   = 1'b0;
                exp_rd[d] = 32'h0;
                chk("rst_we_n", we_n[d], 1);
                chk("rst_oe", dq_oe[d], 0);
                chk("rst_rd", read_data[d], 0);
                chk("rst_addr", sram_addr[d], 0);
                chk("rst_dq", dq_out[d], 0);
                chk("rst_ready", ready[d], !(wr_en[d] || rd_en[d]));
            end else begin
                if (!busy[d] && (wr_en[d] || rd_en[d])) begin
                    busy[d] = 1'b1;
                    k[d]    = 0;
                    opw[d]  = wr_en[d];
                    wi      = (address[d] - 32'd1024) / 4;
                    lo_a[d] = int'((wi * 2) % 32'd262144);
                    wd[d]   = write_data[d];
                end
                if (busy[d]) begin
                    inph = (k[d] >= 1) && (k[d] <= 2 * wc);
                    hiph = k[d] > wc;
                    key  = d * 262144 + lo_a[d];
                    chk("m_ready", ready[d], k[d] == 2 * wc + 1);
                    chk("m_we_n", we_n[d], !(opw[d] && inph));
                    chk("m_oe", dq_oe[d], opw[d] && inph);
                    if (inph) begin
                        exp_a = hiph ? lo_a[d] + 1 : lo_a[d];
                        chk("m_addr", sram_addr[d], exp_a);
                    end
                    if (inph && opw[d])
                        chk("m_dq", dq_out[d],
                            hiph ? wd[d][31:16] : wd[d][15:0]);
                    if (k[d] == 2 * wc + 1) begin
                        if (opw[d]) begin
                            emem[key]     = wd[d][15:0];
                            emem[key + 1] = wd[d][31:16];
                        end else begin
                            exp_rd[d] = {mrd(key + 1), mrd(key)};
                        end
                        chk("m_rd_done", read_data[d], exp_rd[d]);
                        busy[d] = 1'b0;
                    end else if (k[d] == 0) begin
                        chk("m_rd_start", read_data[d], exp_rd[d]);
                    end
                    k[d]++;
                end else begin
                    chk("m_idle_ready", ready[d], 1);
                    chk("m_idle_we_n", we_n[d], 1);
                    chk("m_idle_oe", dq_oe[d], 0);
                    chk("m_idle_rd", read_data[d], exp_rd[d]);
                end
            end
        end
    end

    // Drives a request at posedge+1 and holds it until ready returns.
    task automatic txn(input int d, input bit wr, input bit rd,
                       input logic [31:0] a, input logic [31:0] data,
                       output int lows);
        wr_en[d]      = wr;
        rd_en[d]      = rd;
        address[d]    = a;
        write_data[d] = data;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready[d]) break;
            lows++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        wr_en[d]      = 1'b0;
        rd_en[d]      = 1'b0;
        address[d]    = 32'h0;
        write_data[d] = 32'h0;
        @(posedge clk);
        #1;
    endtask

    int lows;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            wr_en[d]      = 1'b0;
            rd_en[d]      = 1'b0;
            address[d]    = 32'h0;
            write_data[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_ready0", ready[0], 1);
        chk("init_ready1", ready[1], 1);
        @(posedge clk);
        #1;

        txn(0, 1, 0, 32'd1032, 32'hDEADBEEF, lows);
        chk("wr_lows", lows, 11);
        idle(0);
        chk("wr_lo_mem", smem[0][4], 16'hBEEF);
        chk("wr_hi_mem", smem[0][5], 16'hDEAD);
        chk("wr_rd_keep", read_data[0], 32'h0);

        txn(0, 0, 1, 32'd1032, 32'h0, lows);
        chk("rd_lows", lows, 11);
        chk("rd_data", read_data[0], 32'hDEADBEEF);
        idle(0);

        txn(0, 1, 1, 32'd1036, 32'hCAFEF00D, lows);
        chk("both_lows", lows, 11);
        chk("both_rd_keep", read_data[0], 32'hDEADBEEF);
        idle(0);
        chk("both_lo_mem", smem[0][6], 16'hF00D);
        chk("both_hi_mem", smem[0][7], 16'hCAFE);

        txn(1, 1, 0, 32'd1024, 32'hA5A55A5A, lows);
        chk("b2b_wr_lows", lows, 3);
        txn(1, 0, 1, 32'd1024, 32'h0, lows);
        chk("b2b_rd_lows", lows, 3);
        chk("b2b_rd_data", read_data[1], 32'hA5A55A5A);
        idle(1);

        txn(0, 1, 0, 32'd1020, 32'h12345678, lows);
        chk("wrap_lows", lows, 11);
        idle(0);
        chk("wrap_lo_mem", smem[0][18'h3FFFE], 16'h5678);
        chk("wrap_hi_mem", smem[0][18'h3FFFF], 16'h1234);
        txn(0, 0, 1, 32'd1020, 32'h0, lows);
        chk("wrap_rd_data", read_data[0], 32'h12345678);
        idle(0);

        wr_en[0]      = 1'b1;
        address[0]    = 32'd2048;
        write_data[0] = 32'h0BADC0DE;
        repeat (3) @(posedge clk);
        #3;
        chk("mid_we_n_before", we_n[0], 0);
        rst_n    = 1'b0;
        wr_en[0] = 1'b0;
        #1;
        chk("mid_we_n", we_n[0], 1);
        chk("mid_oe", dq_oe[0], 0);
        chk("mid_rd0", read_data[0], 0);
        chk("mid_rd1", read_data[1], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_ready0", ready[0], 1);
        chk("post_ready1", ready[1], 1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory responder for the ARM pipeline. It serves the MEM stage's single-cycle read/write requests from an external 16-bit asynchronous SRAM, splitting each 32-bit word into two half-word accesses. While an access is in flight it holds `ready` low, and the top level uses this to freeze the pipeline. It replaces the ideal data memory behind the MEM stage without changing the MEM stage's request signals.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 5: cycles each half-word phase is held on the SRAM pins. Minimum 1.
- `SRAM_ADDR_W`, 18: SRAM half-word address width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: write request from MEM stage.
- `rd_en` input 1: read request from MEM stage.
- `address` input 32: byte address from the ALU result.
- `write_data` input 32: store data (Val_Rm).
- `read_data` output 32: load data.
- `ready` output 1: 0 = pipeline must freeze.
- `sram_addr` output SRAM_ADDR_W: half-word address.
- `sram_dq_out` output 16: write data to SRAM.
- `sram_dq_in` input 16: read data from SRAM.
- `sram_dq_oe` output 1: 1 = controller drives the DQ bus.
- `sram_we_n` output 1: SRAM write strobe, active-low.

## Operation
- Word index `w = (address - ADDR_BASE) >> 2`, computed as an unsigned 32-bit subtract.
- Low half-word goes to `sram_addr = {w[SRAM_ADDR_W-2:0], 1'b0}`, high half-word to `{w, 1'b1}`. Upper bits are truncated, so out-of-range addresses wrap.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: when `wr_en | rd_en`, latch op (write wins if both are high), address and write_data; go to LO.
  - LO: hold for WAIT_CYCLES cycles using a down-counter, then go to HI.
  - HI: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: go to IDLE unconditionally after one cycle.
- `ready` = 0 in IDLE with a request pending, and in LO and HI. It is 1 otherwise, including DONE and an idle cycle with no request.
- Write phase:
  - `sram_dq_oe` = 1 and `sram_we_n` = 0 for every cycle of LO and HI.
  - `sram_dq_out` = `write_data[15:0]` in LO and `[31:16]` in HI.
- Read phase:
  - `sram_we_n` = 1 and `sram_dq_oe` = 0.
  - `sram_dq_in` is sampled on the last cycle of LO into `read_data[15:0]`, and on the last cycle of HI into `read_data[31:16]`.
- `read_data` holds until the next read overwrites it. Writes do not change it.
- Request inputs are ignored outside IDLE. Deasserting a request mid-transaction does not abort it.
- The requester must hold its inputs stable while `ready` = 0, which the pipeline freeze guarantees.

## Timing
- Reset values (asynchronous, on `rst` = 0): state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` then follows its combinational rule.
- Request first seen at cycle 0 (IDLE): `ready` is low for cycles 0 to 2·WAIT_CYCLES, which is 2·WAIT_CYCLES+1 cycles.
- DONE occurs at cycle 2·WAIT_CYCLES+1: `ready` = 1 and `read_data` is valid. The MEM stage register captures on that clock edge.
- LO occupies cycles 1..WAIT_CYCLES; HI occupies WAIT_CYCLES+1..2·WAIT_CYCLES.
- Back-to-back: a request present in the IDLE cycle after DONE starts immediately. The minimum period is 2·WAIT_CYCLES+2 cycles.
- Reset asserted mid-phase forces `sram_we_n` = 1 and `sram_dq_oe` = 0 at once. The partial write is abandoned.

## Test plan
- Write, WAIT_CYCLES=5:
  - Stimulus: `address`=1032 (w=2), `write_data`=0xDEADBEEF.
  - Response: `ready` low 11 cycles. `sram_addr`=4 with `dq_out`=0xBEEF and `we_n`=0 for 5 cycles, then `sram_addr`=5 with 0xDEAD for 5 cycles. DONE at cycle 11.
- Read:
  - Stimulus: `address`=1032, SRAM model returns 0xBEEF at 4 and 0xDEAD at 5.
  - Response: `read_data`=0xDEADBEEF at cycle 11. `we_n` stays 1 and `dq_oe` stays 0 throughout.
- Simultaneous `rd_en`=`wr_en`=1:
  - Response: a write is performed and `read_data` is unchanged.
- Back-to-back, WAIT_CYCLES=1:
  - Stimulus: write to 1024 held high, then a read of 1024.
  - Response: write `ready` pattern 0,0,0,1. The read starts in the next IDLE cycle and returns the written word after 3 low cycles.
- Reset mid-transaction:
  - Stimulus: `rst`=0 during cycle 3 of the LO write phase.
  - Response: `we_n`=1, `dq_oe`=0, `read_data`=0 with no clock edge required. After release with no request, `ready`=1.
- Wrap:
  - Stimulus: `address`=1020 (below base).
  - Response: w = 0x3FFFFFFF and `sram_addr` = 0x3FFFE / 0x3FFFF. No hang, completes in 11 cycles.
